// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: register index width,
// register count, and default pending-counter / in-flight limits.
package reg_scoreboard_pkg;

    localparam int REGNOBITS       = 5;
    localparam int REGWORDS        = 32;
    localparam int SB_PEND_BITS    = 2;
    localparam int SB_MAX_INFLIGHT = 4;
    localparam int SB_CNT_BITS     = 3;

endpackage

// File: rtl/sb_pend_counter.sv
// Per-register pending-write counter: counts issued writes not yet retired,
// flags a retire with nothing pending, and reports saturation.
import reg_scoreboard_pkg::*;

module sb_pend_counter #(
    parameter int PEND_BITS = SB_PEND_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    output logic [PEND_BITS-1:0] count,
    output logic                 underflow,
    output logic                 saturated
);

    logic [PEND_BITS-1:0] r_count;
    logic                 w_dec_ok;

    assign underflow = dec && (r_count == '0);
    assign saturated = (r_count == '1);
    assign count     = r_count;

    // A retire against an empty counter is discarded, so the count holds at 0
    // and any simultaneous issue still lands.
    assign w_dec_ok  = dec && !underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            unique case ({inc, w_dec_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage issue scoreboard: tracks in-flight writes per register and
// produces the DE stall / issue decision. SCOREBOARD_PERF_EN adds perf counters.
import reg_scoreboard_pkg::*;

module reg_scoreboard #(
    parameter int NUM_REGS     = REGWORDS,
    parameter int PEND_BITS    = SB_PEND_BITS,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int CNT_BITS     = SB_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REGNOBITS-1:0] issue_rs1,
    input  logic [REGNOBITS-1:0] issue_rs2,
    input  logic [REGNOBITS-1:0] issue_rd,
    input  logic                 issue_wr,
    input  logic                 flush,
    input  logic                 wb_valid,
    input  logic [REGNOBITS-1:0] wb_rd,
    output logic                 stall,
    output logic                 issue_ack,
    output logic [CNT_BITS-1:0]  inflight_cnt,
    output logic                 err_underflow
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          issue_count
`endif
);

    logic [PEND_BITS-1:0] w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  w_uf;
    logic [NUM_REGS-1:0]  w_sat;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_dec_ok;
    logic                 w_wr;
    logic [PEND_BITS-1:0] w_eff_rs1;
    logic [PEND_BITS-1:0] w_eff_rs2;
    logic                 w_sat_rd;
    logic                 w_lim;
    logic [CNT_BITS-1:0]  r_inflight;
    logic                 r_err;

    assign w_dec    = wb_valid && (wb_rd != '0);
    assign w_inc    = issue_ack && w_wr;
    assign w_dec_ok = w_dec && !(|w_uf);

    // x0 is never tracked: its slot is a constant zero.
    assign w_cnt[0] = '0;
    assign w_uf[0]  = 1'b0;
    assign w_sat[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        localparam logic [REGNOBITS-1:0] IDX = REGNOBITS'(r);
        sb_pend_counter #(
            .PEND_BITS(PEND_BITS)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (w_inc && (issue_rd == IDX)),
            .dec       (w_dec && (wb_rd == IDX)),
            .count     (w_cnt[r]),
            .underflow (w_uf[r]),
            .saturated (w_sat[r])
        );
    end

    // Effective counts subtract a same-cycle WB retire, since the register
    // file writes on negedge and the value is readable this cycle.
    always_comb begin
        w_wr      = issue_wr && (issue_rd != '0);
        w_eff_rs1 = w_cnt[issue_rs1] - PEND_BITS'(w_dec && (wb_rd == issue_rs1));
        w_eff_rs2 = w_cnt[issue_rs2] - PEND_BITS'(w_dec && (wb_rd == issue_rs2));
        w_sat_rd  = w_sat[issue_rd] && !(w_dec && (wb_rd == issue_rd));
        w_lim     = (r_inflight - CNT_BITS'(w_dec)) == CNT_BITS'(MAX_INFLIGHT);
        stall     = issue_valid && !reset &&
                    (((issue_rs1 != '0) && (w_eff_rs1 != '0)) ||
                     ((issue_rs2 != '0) && (w_eff_rs2 != '0)) ||
                     (w_wr && (w_sat_rd || w_lim)));
        issue_ack = issue_valid && !stall && !flush && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= r_inflight + CNT_BITS'(w_inc) - CNT_BITS'(w_dec_ok);
            if (|w_uf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign inflight_cnt  = r_inflight;
    assign err_underflow = r_err;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_issue_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_issue_count  <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + 32'(stall);
            r_issue_count  <= r_issue_count + 32'(issue_ack);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign issue_count  = r_issue_count;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: reset, RAW bypass,
// saturation, in-flight limit, flush, underflow and mid-stream reset.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic [4:0] issue_rd;
    logic       issue_wr;
    logic       flush;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       stall;
    logic       issue_ack;
    logic [2:0] inflight_cnt;
    logic       err_underflow;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] issue_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_wr      (issue_wr),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .stall         (stall),
        .issue_ack     (issue_ack),
        .inflight_cnt  (inflight_cnt),
        .err_underflow (err_underflow)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .issue_count   (issue_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs on the falling edge; combinational outputs settle by #1.
    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic w, input logic f,
                         input logic wv, input logic [4:0] wr);
        @(negedge clk);
        issue_valid = v;
        issue_rs1   = s1;
        issue_rs2   = s2;
        issue_rd    = d;
        issue_wr    = w;
        flush       = f;
        wb_valid    = wv;
        wb_rd       = wr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ack", issue_ack, 0);
        tick();
        tick();
        chk("rst_inflight", inflight_cnt, 0);
        chk("rst_err", err_underflow, 0);

        // idle x0 instruction
        reset = 1'b0;
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        chk("x0_ack", issue_ack, 1);
        chk("x0_stall", stall, 0);
        tick();
        chk("x0_inflight", inflight_cnt, 0);

        // RAW hazard with same-cycle retire bypass
        drive(1, 0, 0, 5, 1, 0, 0, 0);
        chk("raw_issue_ack", issue_ack, 1);
        tick();
        chk("raw_inflight1", inflight_cnt, 1);
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        chk("raw_stall_a", stall, 1);
        chk("raw_ack_a", issue_ack, 0);
        tick();
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        chk("raw_stall_rs2", stall, 1);
        tick();
        drive(1, 5, 0, 0, 0, 0, 1, 5);
        chk("raw_bypass_stall", stall, 0);
        chk("raw_bypass_ack", issue_ack, 1);
        tick();
        chk("raw_inflight0", inflight_cnt, 0);

        // per-register saturation on x7
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 7, 1, 0, 0, 0);
            chk("sat_issue_ack", issue_ack, 1);
            tick();
        end
        chk("sat_inflight3", inflight_cnt, 3);
        drive(1, 0, 0, 7, 1, 0, 0, 0);
        chk("sat_stall", stall, 1);
        chk("sat_ack", issue_ack, 0);
        tick();
        drive(1, 0, 0, 7, 1, 0, 1, 7);
        chk("sat_release_stall", stall, 0);
        chk("sat_release_ack", issue_ack, 1);
        tick();
        chk("sat_inflight_hold", inflight_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 7);
            tick();
        end
        chk("sat_drain", inflight_cnt, 0);
        chk("sat_no_err", err_underflow, 0);

        // total in-flight limit
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 5'(i), 1, 0, 0, 0);
            chk("lim_issue_ack", issue_ack, 1);
            tick();
        end
        chk("lim_inflight4", inflight_cnt, 4);
        drive(1, 0, 0, 6, 1, 0, 0, 0);
        chk("lim_stall", stall, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lim_nowr_ack", issue_ack, 1);
        drive(1, 0, 0, 6, 1, 0, 1, 1);
        chk("lim_release_stall", stall, 0);
        chk("lim_release_ack", issue_ack, 1);
        tick();
        chk("lim_inflight_hold", inflight_cnt, 4);
        drive(0, 0, 0, 0, 0, 0, 1, 2); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 3); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 4); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 6); tick();
        chk("lim_drain", inflight_cnt, 0);

        // flush squashes issue but not stall
        drive(1, 0, 0, 9, 1, 1, 0, 0);
        chk("flush_ack", issue_ack, 0);
        chk("flush_stall", stall, 0);
        tick();
        chk("flush_inflight", inflight_cnt, 0);
        drive(1, 9, 0, 0, 0, 0, 0, 0);
        chk("flush_rs1_stall", stall, 0);
        chk("flush_rs1_ack", issue_ack, 1);
        tick();
        drive(1, 0, 0, 10, 1, 0, 0, 0);
        tick();
        drive(1, 10, 0, 0, 0, 1, 0, 0);
        chk("flush_keeps_stall", stall, 1);
        chk("flush_keeps_ack", issue_ack, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 10);
        tick();
        chk("flush_drain", inflight_cnt, 0);

        // x0 retire is ignored, x3 retire underflows
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("x0_wb_err", err_underflow, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        chk("uf_err", err_underflow, 1);
        chk("uf_inflight", inflight_cnt, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        chk("uf_cnt_zero", stall, 0);
        tick();
        chk("uf_sticky", err_underflow, 1);

        // reset mid-stream discards all state
        drive(1, 0, 0, 12, 1, 0, 0, 0);
        tick();
        chk("mid_inflight1", inflight_cnt, 1);
        reset = 1'b1;
        drive(1, 12, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_ack", issue_ack, 0);
        tick();
        chk("mid_rst_inflight", inflight_cnt, 0);
        chk("mid_rst_err", err_underflow, 0);
        reset = 1'b0;
        drive(1, 12, 0, 0, 0, 0, 0, 0);
        chk("mid_cnt_cleared", stall, 0);
        chk("mid_ack", issue_ack, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register scoreboard controlling issue from the decode stage.
- Tracks in-flight writes to each architectural register, counting from DE issue to WB retire.
- Produces the DE stall decision; replaces direct rd comparisons against AGEX/MEM/WB.
- Sits beside the decode stage: DE presents the candidate instruction and WB reports retirements.

Parameters:
NUM_REGS, 32, number of architectural registers tracked (x0 never tracked)
PEND_BITS, 2, width of each per-register pending counter (max 3 outstanding writes per register)
MAX_INFLIGHT, 4, maximum total outstanding register-writing instructions
CNT_BITS, 3, width of the total in-flight counter (must hold MAX_INFLIGHT)

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  DE holds a valid decoded instruction
issue_rs1  in  5  source register 1 (0 = unused)
issue_rs2  in  5  source register 2 (0 = unused)
issue_rd  in  5  destination register
issue_wr  in  1  instruction writes issue_rd
flush  in  1  branch redirect from AGEX; the DE instruction is squashed
wb_valid  in  1  WB retires a register write this cycle
wb_rd  in  5  register retired by WB
stall  out  1  DE must hold; FE must not advance
issue_ack  out  1  instruction issued into AGEX this cycle
inflight_cnt  out  CNT_BITS  total outstanding writes
err_underflow  out  1  sticky; WB retired a register that had no pending write

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state: all pending counters 0, inflight_cnt 0, err_underflow 0.
- During reset, stall and issue_ack are forced to 0. The same applies on reset asserted mid-operation; all tracked state is discarded.
- Effective pending count (combinational): eff[r] = cnt[r] - (wb_valid && wb_rd==r && r!=0).
  - This is the same-cycle retire bypass. The register file writes on negedge, so the WB value is readable in the same cycle.
- Stall conditions (combinational). stall = issue_valid && !reset && any of:
  - issue_rs1!=0 && eff[issue_rs1]!=0
  - issue_rs2!=0 && eff[issue_rs2]!=0
  - issue_wr && issue_rd!=0 && eff[issue_rd]==2^PEND_BITS-1 (per-register saturation)
  - issue_wr && issue_rd!=0 && inflight_cnt - (wb_valid && wb_rd!=0) == MAX_INFLIGHT
- issue_ack = issue_valid && !stall && !flush && !reset.
  - flush suppresses issue_ack but not stall.
  - Flushed instructions never touch counters.
- Counter updates at posedge. Let inc = issue_ack && issue_wr && issue_rd!=0, and dec = wb_valid && wb_rd!=0.
  - cnt[issue_rd] += inc; cnt[wb_rd] -= dec.
  - Same register on both events: the counter is unchanged.
  - inflight_cnt += inc - dec. Latency from issue or retire to count visible: 1 cycle.
- Underflow: dec while cnt[wb_rd]==0 sets err_underflow, which stays set until reset. The counter holds at 0 (no wrap), and inflight_cnt also holds.
- x0: never incremented or decremented, never causes a stall, never flags underflow.
- Overflow is impossible by construction; the saturation stall prevents it.

Optional Feature:
- Macro: SCOREBOARD_PERF_EN.
- When defined:
  - adds output stall_cycles [31:0], counting cycles with stall=1, reset to 0, wrapping at 2^32;
  - adds output issue_count [31:0], counting issue_ack pulses.
- When undefined: neither port nor counter exists, and the remaining behaviour is identical.

Decomposition:
- Shared define header: REGNOBITS, REGWORDS, and new SB_PEND_BITS and SB_MAX_INFLIGHT defaults.
- Natural sub-module: sb_pend_counter, one per register, instantiated NUM_REGS-1 times.
  - Inputs: inc, dec, clk, reset.
  - Outputs: count, underflow, saturated.
- Top level holds the stall logic, in-flight counter, error flag and perf counters.

Test Plan:
- Reset then idle: all outputs 0; issue_valid=1 with rs1=rs2=rd=0 -> issue_ack=1, stall=0, inflight_cnt remains 0.
- RAW hazard: issue rd=5 wr=1; next cycle issue rs1=5 -> stall=1 until wb_valid wb_rd=5. In the WB cycle stall=0 and issue_ack=1 (bypass).
- Saturation: issue rd=7 three times with no retire -> cnt[7]=3; a fourth write to 7 -> stall=1. One retire of 7 in the same cycle -> issue_ack=1.
- In-flight limit: issue writes to x1..x4 -> inflight_cnt=4; write to x6 stalls; a simultaneous wb_rd=1 releases it and inflight_cnt stays 4.
- Flush: issue_valid rd=9 with flush=1 -> issue_ack=0 and cnt[9] stays 0; a later rs1=9 does not stall.
- Underflow and reset: wb_valid wb_rd=3 with cnt[3]=0 -> err_underflow=1 sticky and cnt[3]=0; reset asserted mid-stream -> all counters and the flag read 0 next cycle.
